// File: rtl/entropy_encoder_pkg.sv
// Shared constants and types for the block-prediction entropy encoder.
// Codeword geometry, sub-sampling modes and the registered output bundle.
package entropy_encoder_pkg;

    localparam int ECG_BITS     = 50;
    localparam int SIZE_BITS    = 7;
    localparam int SIGN_BITS    = 4;
    localparam int MAX_MAG_BITS = 10;
    localparam int LEN_BITS     = 4;
    localparam int NUM_SAMPLES  = 4;

    localparam logic [1:0] SS_FULL    = 2'b00;
    localparam logic [1:0] SS_HALF    = 2'b01;
    localparam logic [1:0] SS_QUARTER = 2'b10;

    typedef struct packed {
        logic [ECG_BITS-1:0]  enc;
        logic [SIZE_BITS-1:0] size;
        logic                 valid;
        logic [SIGN_BITS-1:0] sgn;
        logic [2:0]           sgn_size;
    } ecg_out_t;

    // Bit i set means sample i+1 takes part in the ECG.
    function automatic logic [NUM_SAMPLES-1:0] active_mask(
        input logic [1:0] comp,
        input logic [1:0] ss
    );
        logic [NUM_SAMPLES-1:0] m;
        m = 4'b1111;
        if (comp != 2'd0) begin
            unique case (ss)
                SS_HALF:    m = 4'b0011;
                SS_QUARTER: m = 4'b0001;
                default:    m = 4'b1111;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/entropy_encoder_mag_len.sv
// Magnitude, bit length and sign of one signed residual.
// Magnitude is one bit wider so the most negative value cannot overflow.
module ecg_mag_len
    import entropy_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 10
) (
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH:0]   mag,
    output logic [LEN_BITS-1:0]   len,
    output logic                  neg
);

    always_comb begin
        neg = sample[DATA_WIDTH-1];
        if (neg) begin
            mag = ~{sample[DATA_WIDTH-1], sample} + 1'b1;
        end else begin
            mag = {1'b0, sample};
        end
        len = '0;
        for (int b = 0; b <= DATA_WIDTH; b++) begin
            if (mag[b]) len = LEN_BITS'(b + 1);
        end
    end

endmodule

// File: rtl/entropy_encoder.sv
// ECG encoder: unary size prefix plus fixed-width magnitudes, MSB aligned,
// with compacted sign bits; one registered stage, one ECG per cycle.
module entropy_encoder
    import entropy_encoder_pkg::*;
#(
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] sample_1,
    input  logic [DATA_WIDTH-1:0] sample_2,
    input  logic [DATA_WIDTH-1:0] sample_3,
    input  logic [DATA_WIDTH-1:0] sample_4,
    input  logic [11:0]           sign_bits_in,
    input  logic [3:0]            sizeof_sign_bits_in,
    input  logic [7:0]            sizeof_stuffing_bits,
    input  logic [1:0]            ecgidx,
    input  logic [1:0]            sub_sample_info,
    input  logic [1:0]            component_idx,
    input  logic                  component_skip,
    input  logic                  underflow_prevention,
    output logic [49:0]           encoded_ECG,
    output logic [6:0]            sizeof_encoded_ECG,
    output logic                  valid_op,
    output logic [3:0]            sign_bits_out,
    output logic [2:0]            sizeof_sign_bits_out
);

    logic [DATA_WIDTH-1:0] smp [NUM_SAMPLES];
    logic [DATA_WIDTH:0]   mag [NUM_SAMPLES];
    logic [LEN_BITS-1:0]   len [NUM_SAMPLES];
    logic [NUM_SAMPLES-1:0] neg;

    assign smp[0] = sample_1;
    assign smp[1] = sample_2;
    assign smp[2] = sample_3;
    assign smp[3] = sample_4;

    for (genvar g = 0; g < NUM_SAMPLES; g++) begin : g_mag
        ecg_mag_len #(.DATA_WIDTH(DATA_WIDTH)) u_mag (
            .sample (smp[g]),
            .mag    (mag[g]),
            .len    (len[g]),
            .neg    (neg[g])
        );
    end

    logic unused_inputs;
    assign unused_inputs = ^{sign_bits_in, sizeof_sign_bits_in, ecgidx};

    ecg_out_t               out_d, out_q;
    logic [NUM_SAMPLES-1:0] act;
    logic [LEN_BITS-1:0]    m;
    logic [SIZE_BITS-1:0]   m_w, pos, shamt;
    logic [ECG_BITS-1:0]    acc;
    logic [SIGN_BITS-1:0]   sg;
    logic [2:0]             cnt;

    always_comb begin
        act = active_mask(component_idx, sub_sample_info);
        m = '0;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            if (act[i] && len[i] > m) m = len[i];
        end
        m_w = SIZE_BITS'(m);
        // Full-width prefix drops its terminator so the worst case fits.
        if (m == LEN_BITS'(MAX_MAG_BITS)) pos = m_w;
        else                              pos = m_w + 7'd1;
        acc   = ~({ECG_BITS{1'b1}} >> m);
        shamt = '0;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            if (act[i]) begin
                shamt = SIZE_BITS'(ECG_BITS) - pos - m_w;
                acc   = acc | (ECG_BITS'(mag[i]) << shamt);
                pos   = pos + m_w;
            end
        end
        sg  = '0;
        cnt = '0;
        for (int i = 0; i < NUM_SAMPLES; i++) begin
            if (act[i] && (|mag[i])) begin
                if (neg[i]) sg = sg | (4'b1000 >> cnt);
                cnt = cnt + 3'd1;
            end
        end

        out_d = '0;
        if (component_skip) begin
            out_d = '0;
        end else if (underflow_prevention) begin
            out_d.valid = 1'b1;
            if (sizeof_stuffing_bits > 8'(ECG_BITS)) out_d.size = SIZE_BITS'(ECG_BITS);
            else out_d.size = sizeof_stuffing_bits[SIZE_BITS-1:0];
        end else begin
            out_d.valid    = 1'b1;
            out_d.enc      = acc;
            out_d.size     = pos;
            out_d.sgn      = sg;
            out_d.sgn_size = cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) out_q <= '0;
        else      out_q <= out_d;
    end

    assign encoded_ECG          = out_q.enc;
    assign sizeof_encoded_ECG   = out_q.size;
    assign valid_op             = out_q.valid;
    assign sign_bits_out        = out_q.sgn;
    assign sizeof_sign_bits_out = out_q.sgn_size;

endmodule

// File: tb/tb_entropy_encoder.sv
// Scoreboard bench for entropy_encoder: a bit-serial reference model
// queues expected outputs at drive time, compared one cycle later.
module tb_entropy_encoder;

    typedef struct {
        logic [49:0] enc;
        logic [6:0]  sz;
        logic        v;
        logic [3:0]  sg;
        logic [2:0]  ssz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  s1, s2, s3, s4;
    logic [11:0] sb_in;
    logic [3:0]  ssb_in;
    logic [7:0]  stuff;
    logic [1:0]  ecgidx, ss, comp;
    logic        skip, uf;
    logic [49:0] enc;
    logic [6:0]  enc_sz;
    logic        vld;
    logic [3:0]  sgn;
    logic [2:0]  sgn_sz;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    entropy_encoder #(.DATA_WIDTH(10)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .sample_1             (s1),
        .sample_2             (s2),
        .sample_3             (s3),
        .sample_4             (s4),
        .sign_bits_in         (sb_in),
        .sizeof_sign_bits_in  (ssb_in),
        .sizeof_stuffing_bits (stuff),
        .ecgidx               (ecgidx),
        .sub_sample_info      (ss),
        .component_idx        (comp),
        .component_skip       (skip),
        .underflow_prevention (uf),
        .encoded_ECG          (enc),
        .sizeof_encoded_ECG   (enc_sz),
        .valid_op             (vld),
        .sign_bits_out        (sgn),
        .sizeof_sign_bits_out (sgn_sz)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        int   smp [4];
        int   mg [4];
        int   n, mx, m, idx, sc;
        e = '{enc: '0, sz: '0, v: 1'b0, sg: '0, ssz: '0};
        if (skip) return e;
        e.v = 1'b1;
        if (uf) begin
            e.sz = (stuff > 50) ? 7'd50 : stuff[6:0];
            return e;
        end
        smp[0] = $signed(s1);
        smp[1] = $signed(s2);
        smp[2] = $signed(s3);
        smp[3] = $signed(s4);
        n = 4;
        if (comp != 0 && ss == 2'b01) n = 2;
        if (comp != 0 && ss == 2'b10) n = 1;
        mx = 0;
        for (int i = 0; i < 4; i++) begin
            mg[i] = (smp[i] < 0) ? -smp[i] : smp[i];
            if (i < n && mg[i] > mx) mx = mg[i];
        end
        m = 0;
        while ((mx >> m) != 0) m++;
        idx = 49;
        for (int k = 0; k < m; k++) begin
            e.enc[idx] = 1'b1;
            idx--;
        end
        if (m < 10) idx--;
        for (int i = 0; i < n; i++) begin
            for (int b = m - 1; b >= 0; b--) begin
                e.enc[idx] = mg[i][b];
                idx--;
            end
        end
        e.sz = 7'(49 - idx);
        sc = 0;
        for (int i = 0; i < n; i++) begin
            if (mg[i] != 0) begin
                e.sg[3 - sc] = (smp[i] < 0);
                sc++;
            end
        end
        e.ssz = 3'(sc);
        return e;
    endfunction

    task automatic drive(input int a, input int b, input int c, input int d,
                         input logic [1:0] cm, input logic [1:0] sm,
                         input logic sk, input logic u, input logic [7:0] st);
        s1 = 10'(a);
        s2 = 10'(b);
        s3 = 10'(c);
        s4 = 10'(d);
        comp = cm;
        ss = sm;
        skip = sk;
        uf = u;
        stuff = st;
        sb_in = 12'($urandom);
        ssb_in = 4'($urandom);
        ecgidx = 2'($urandom);
        sbq.push_back(model());
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            check({tag, "_queue"}, 64'd0, 64'd1);
            return;
        end
        e = sbq.pop_front();
        check({tag, "_enc"}, 64'(enc), 64'(e.enc));
        check({tag, "_size"}, 64'(enc_sz), 64'(e.sz));
        check({tag, "_valid"}, 64'(vld), 64'(e.v));
        check({tag, "_sign"}, 64'(sgn), 64'(e.sg));
        check({tag, "_signsz"}, 64'(sgn_sz), 64'(e.ssz));
    endtask

    task automatic step(input string tag, input int a, input int b,
                        input int c, input int d, input logic [1:0] cm,
                        input logic [1:0] sm, input logic sk, input logic u,
                        input logic [7:0] st);
        @(negedge clk);
        drive(a, b, c, d, cm, sm, sk, u, st);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_enc"}, 64'(enc), 64'd0);
        check({tag, "_size"}, 64'(enc_sz), 64'd0);
        check({tag, "_valid"}, 64'(vld), 64'd0);
        check({tag, "_sign"}, 64'(sgn), 64'd0);
        check({tag, "_signsz"}, 64'(sgn_sz), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        drive(1, 2, 3, 4, 2'd0, 2'd0, 1'b0, 1'b0, 8'd0);
        void'(sbq.pop_front());
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");

        @(negedge clk);
        rst = 1'b1;

        step("luma_mix", 3, -1, 0, 2, 2'd0, 2'd0, 1'b0, 1'b0, 8'd0);
        check("tp_prefix_suffix", 64'(enc[49:39]), 64'(11'b110_11_01_00_10));
        check("tp_size", 64'(enc_sz), 64'd11);
        check("tp_sign", 64'(sgn), 64'(4'b0100));

        step("luma_zero", 0, 0, 0, 0, 2'd0, 2'd0, 1'b0, 1'b0, 8'd0);
        check("tp_zero_size", 64'(enc_sz), 64'd1);

        step("luma_min", -512, 0, 0, 0, 2'd0, 2'd0, 1'b0, 1'b0, 8'd0);
        check("tp_min_prefix", 64'(enc[49:40]), 64'(10'h3ff));
        check("tp_min_mag", 64'(enc[39:30]), 64'(10'b1000000000));
        check("tp_min_size", 64'(enc_sz), 64'd50);

        step("chroma_half", 5, -2, 7, 7, 2'd1, 2'b01, 1'b0, 1'b0, 8'd0);
        check("tp_half_cw", 64'(enc[49:40]), 64'(10'b1110_101_010));
        check("tp_half_size", 64'(enc_sz), 64'd10);

        step("chroma_qtr", -7, 300, 300, 300, 2'd2, 2'b10, 1'b0, 1'b0, 8'd0);
        step("chroma_ss11", 1, -1, 1, -1, 2'd2, 2'b11, 1'b0, 1'b0, 8'd0);
        step("luma_ss10", 1, 2, 4, -8, 2'd0, 2'b10, 1'b0, 1'b0, 8'd0);
        step("max_all", 511, -511, -512, 256, 2'd0, 2'd0, 1'b0, 1'b0, 8'd0);
        step("uf_80", 3, 3, 3, 3, 2'd0, 2'd0, 1'b0, 1'b1, 8'd80);
        check("tp_uf_size", 64'(enc_sz), 64'd50);
        step("uf_17", 3, 3, 3, 3, 2'd0, 2'd0, 1'b0, 1'b1, 8'd17);
        step("uf_50", 3, 3, 3, 3, 2'd0, 2'd0, 1'b0, 1'b1, 8'd50);
        step("skip", 3, -3, 3, 3, 2'd0, 2'd0, 1'b1, 1'b1, 8'd80);
        check("tp_skip_valid", 64'(vld), 64'd0);

        step("pre_rst", 9, -9, 1, 0, 2'd0, 2'd0, 1'b0, 1'b0, 8'd0);
        #2;
        rst = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        drive(-100, 6, 0, -1, 2'd0, 2'd0, 1'b0, 1'b0, 8'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        compare("post_rst");

        for (int t = 0; t < 60; t++) begin
            int a, b, c, d;
            logic [1:0] cm, sm;
            logic sk, u;
            if (t % 2 == 0) begin
                a = $urandom_range(0, 1023) - 512;
                b = $urandom_range(0, 1023) - 512;
                c = $urandom_range(0, 1023) - 512;
                d = $urandom_range(0, 1023) - 512;
            end else begin
                a = $urandom_range(0, 15) - 8;
                b = $urandom_range(0, 15) - 8;
                c = $urandom_range(0, 15) - 8;
                d = $urandom_range(0, 15) - 8;
            end
            cm = 2'($urandom_range(0, 2));
            sm = 2'($urandom);
            sk = ($urandom_range(0, 9) == 0);
            u  = ($urandom_range(0, 7) == 0);
            step("rand", a, b, c, d, cm, sm, sk, u, 8'($urandom));
        end

        check("queue_empty", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
